// File: rtl/noc_pkg.sv
// Shared NoC constants and a constant-safe ceiling-log2 helper.
package noc_pkg;

  localparam int FLIT_W_DEF = 8;
  localparam int DEST_W_DEF = 2;

  // Never returns less than 1, so that index/pointer vectors stay legal for tiny sizes.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// Single-VC first-word-fall-through FIFO: a push is visible at the head one cycle later.
// The caller gates push with !full; a pop happens only on valid && pop_ready.
module vc_fifo
  import noc_pkg::*;
#(
  parameter  int FLIT_W = FLIT_W_DEF,
  parameter  int DEPTH  = 4,
  localparam int PTR_W  = clog2(DEPTH),
  localparam int CNT_W  = clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_flit,
  input  logic              pop_ready,
  output logic              valid,
  output logic [FLIT_W-1:0] head,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              wr_en;
  logic              rd_en;

  assign valid = (count != '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign wr_en = push & ~full;
  assign rd_en = valid & pop_ready;
  // Gating by valid makes the head read 0 while empty, including straight out of reset.
  assign head  = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_flit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vc_buffer_bank.sv
// Bank of NUM_VC independent FWFT flit FIFOs with one write port; one-cycle latency into an empty VC.
// in_ready depends only on the target VC being valid and not full; refused flits set sticky err_drop.
module vc_buffer_bank
  import noc_pkg::*;
#(
  parameter  int FLIT_W   = FLIT_W_DEF,
  parameter  int NUM_VC   = 2,
  parameter  int DEPTH    = 4,
  parameter  int DEST_W   = DEST_W_DEF,
  localparam int VC_IDX_W = clog2(NUM_VC),
  localparam int CNT_W    = clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [VC_IDX_W-1:0]      in_vc,
  input  logic [FLIT_W-1:0]        in_flit,
  output logic                     in_ready,
  input  logic [NUM_VC-1:0]        out_ready,
  output logic [NUM_VC-1:0]        out_valid,
  output logic [NUM_VC*FLIT_W-1:0] out_flit,
  output logic [NUM_VC*DEST_W-1:0] out_dest,
  output logic [NUM_VC-1:0]        vc_full,
  output logic [NUM_VC*CNT_W-1:0]  vc_count,
  output logic                     err_drop
);

  logic vc_ok;
  logic sel_full;

  // With a power-of-two VC count every encodable index is a real VC.
  generate
    if (NUM_VC == (1 << VC_IDX_W)) begin : g_idx_full
      assign vc_ok = 1'b1;
    end else begin : g_idx_part
      assign vc_ok = (in_vc < VC_IDX_W'(NUM_VC));
    end
  endgenerate

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (in_vc == VC_IDX_W'(i)) sel_full = vc_full[i];
    end
  end

  assign in_ready = vc_ok & ~sel_full;

  generate
    for (genvar gi = 0; gi < NUM_VC; gi++) begin : g_vc
      vc_fifo #(
        .FLIT_W (FLIT_W),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid & in_ready & (in_vc == VC_IDX_W'(gi))),
        .push_flit (in_flit),
        .pop_ready (out_ready[gi]),
        .valid     (out_valid[gi]),
        .head      (out_flit[gi*FLIT_W +: FLIT_W]),
        .full      (vc_full[gi]),
        .count     (vc_count[gi*CNT_W +: CNT_W])
      );
      assign out_dest[gi*DEST_W +: DEST_W] = out_flit[gi*FLIT_W +: DEST_W];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       err_drop <= 1'b0;
    else if (in_valid && !in_ready) err_drop <= 1'b1;
  end

endmodule

// File: tb/tb_vc_buffer_bank.sv
// Directed bench for vc_buffer_bank with default parameters (8-bit flits, 2 VCs, depth 4).
module tb_vc_buffer_bank;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [0:0]  in_vc;
  logic [7:0]  in_flit;
  logic        in_ready;
  logic [1:0]  out_ready;
  logic [1:0]  out_valid;
  logic [15:0] out_flit;
  logic [3:0]  out_dest;
  logic [1:0]  vc_full;
  logic [5:0]  vc_count;
  logic        err_drop;

  int passed = 0;
  int total  = 0;

  vc_buffer_bank dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_vc     (in_vc),
    .in_flit   (in_flit),
    .in_ready  (in_ready),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_flit  (out_flit),
    .out_dest  (out_dest),
    .vc_full   (vc_full),
    .vc_count  (vc_count),
    .err_drop  (err_drop)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       iv;
    logic       vc;
    logic [7:0] flit;
    logic [1:0] ordy;
    logic       rdy;
    logic [1:0] ov;
    int         c0;
    int         c1;
    logic [7:0] h0;
    logic [7:0] h1;
    logic       err;
    logic [1:0] full;
  } vec_t;

  vec_t vt[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else passed++;
  endtask

  task automatic drive(input logic iv, input logic vc, input logic [7:0] f, input logic [1:0] ordy);
    in_valid  = iv;
    in_vc     = vc;
    in_flit   = f;
    out_ready = ordy;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [7:0] q[$];
  logic [7:0] exp_head;

  initial begin
    // inputs               | rdy | ov  | c0 c1 | h0    h1   | err full
    vt[0] = '{1'b1, 1'b0, 8'hA1, 2'b00, 1'b1, 2'b01, 1, 0, 8'hA1, 8'h00, 1'b0, 2'b00};
    vt[1] = '{1'b1, 1'b1, 8'h11, 2'b00, 1'b1, 2'b11, 1, 1, 8'hA1, 8'h11, 1'b0, 2'b00};
    vt[2] = '{1'b1, 1'b1, 8'h12, 2'b00, 1'b1, 2'b11, 1, 2, 8'hA1, 8'h11, 1'b0, 2'b00};
    vt[3] = '{1'b1, 1'b1, 8'h13, 2'b00, 1'b1, 2'b11, 1, 3, 8'hA1, 8'h11, 1'b0, 2'b00};
    vt[4] = '{1'b1, 1'b1, 8'h14, 2'b00, 1'b1, 2'b11, 1, 4, 8'hA1, 8'h11, 1'b0, 2'b10};
    // Full VC1 with a pop requested: in_ready stays low, flit dropped, pop still happens.
    vt[5] = '{1'b1, 1'b1, 8'h15, 2'b10, 1'b0, 2'b11, 1, 3, 8'hA1, 8'h12, 1'b1, 2'b00};
    vt[6] = '{1'b1, 1'b0, 8'hB2, 2'b00, 1'b1, 2'b11, 2, 3, 8'hA1, 8'h12, 1'b1, 2'b00};
    vt[7] = '{1'b0, 1'b0, 8'h00, 2'b11, 1'b1, 2'b11, 1, 2, 8'hB2, 8'h13, 1'b1, 2'b00};
    vt[8] = '{1'b0, 1'b1, 8'h00, 2'b00, 1'b1, 2'b11, 1, 2, 8'hB2, 8'h13, 1'b1, 2'b00};

    do_reset();
    check("reset out_valid", out_valid, 2'b00);
    check("reset vc_full", vc_full, 2'b00);
    check("reset vc_count", vc_count, 6'd0);
    check("reset err_drop", err_drop, 1'b0);
    check("reset out_flit", out_flit, 16'h0000);
    check("reset out_dest", out_dest, 4'h0);

    for (int i = 0; i < 9; i++) begin
      drive(vt[i].iv, vt[i].vc, vt[i].flit, vt[i].ordy);
      #1 check($sformatf("row%0d in_ready", i), in_ready, vt[i].rdy);
      @(posedge clk);
      #1;
      check($sformatf("row%0d out_valid", i), out_valid, vt[i].ov);
      check($sformatf("row%0d count0", i), vc_count[2:0], vt[i].c0);
      check($sformatf("row%0d count1", i), vc_count[5:3], vt[i].c1);
      check($sformatf("row%0d vc_full", i), vc_full, vt[i].full);
      check($sformatf("row%0d err_drop", i), err_drop, vt[i].err);
      if (vt[i].ov[0]) begin
        check($sformatf("row%0d head0", i), out_flit[7:0], vt[i].h0);
        check($sformatf("row%0d dest0", i), out_dest[1:0], vt[i].h0[1:0]);
      end
      if (vt[i].ov[1]) begin
        check($sformatf("row%0d head1", i), out_flit[15:8], vt[i].h1);
        check($sformatf("row%0d dest1", i), out_dest[3:2], vt[i].h1[1:0]);
      end
    end

    // Steady push+pop on VC0 holding two flits, across several pointer wraps.
    do_reset();
    q.delete();
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, 1'b0, 8'h20 + 8'(k), 2'b00);
      @(posedge clk);
      q.push_back(8'h20 + 8'(k));
      #1;
    end
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 1'b0, 8'h22 + 8'(k), 2'b01);
      #1 exp_head = q[0];
      check($sformatf("wrap head%0d", k), out_flit[7:0], exp_head);
      @(posedge clk);
      void'(q.pop_front());
      q.push_back(8'h22 + 8'(k));
      #1 check($sformatf("wrap count%0d", k), vc_count[2:0], 3'd2);
    end
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 8'h00, 2'b01);
      #1 exp_head = q[0];
      check($sformatf("drain head%0d", k), out_flit[7:0], exp_head);
      @(posedge clk);
      void'(q.pop_front());
      #1;
    end
    check("drain count", vc_count[2:0], 3'd0);

    // All-zero flit into empty VC0 with out_ready already high: push only, pop next edge.
    drive(1'b1, 1'b0, 8'h00, 2'b01);
    @(posedge clk);
    #1;
    check("zero flit count", vc_count[2:0], 3'd1);
    check("zero flit valid", out_valid, 2'b01);
    check("zero flit data", out_flit[7:0], 8'h00);
    drive(1'b0, 1'b0, 8'h00, 2'b01);
    @(posedge clk);
    #1 check("zero flit popped", vc_count[2:0], 3'd0);

    // Fill both VCs, provoke a drop, then reset mid-stream.
    for (int v = 0; v < 2; v++) begin
      for (int k = 0; k < 4; k++) begin
        drive(1'b1, 1'(v), 8'h40 + 8'(v * 4 + k), 2'b00);
        @(posedge clk);
        #1;
      end
    end
    drive(1'b1, 1'b1, 8'hEE, 2'b00);
    @(posedge clk);
    #1;
    check("fill full", vc_full, 2'b11);
    check("fill err", err_drop, 1'b1);
    drive(1'b0, 1'b0, 8'h00, 2'b00);
    #2 rst = 1'b1;
    #1;
    check("midrst out_valid", out_valid, 2'b00);
    check("midrst vc_full", vc_full, 2'b00);
    check("midrst vc_count", vc_count, 6'd0);
    check("midrst err_drop", err_drop, 1'b0);
    check("midrst out_flit", out_flit, 16'h0000);
    check("midrst out_dest", out_dest, 4'h0);
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1'b1, 1'b1, 8'h5A, 2'b00);
    #1 check("post rst not yet", out_valid, 2'b00);
    @(posedge clk);
    #1;
    check("post rst valid", out_valid, 2'b10);
    check("post rst flit", out_flit[15:8], 8'h5A);
    check("post rst count", vc_count[5:3], 3'd1);
    drive(1'b0, 1'b0, 8'h00, 2'b00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
